// File: rtl/rv32i_boot_pkg.sv
// Shared types and constants for the rv32i boot/run controller.
// Holds the controller state encoding, default run limits and a constant-safe clog2.
package rv32i_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RF_INIT,
        LOAD,
        RUN,
        DONE
    } boot_state_e;

    localparam int unsigned DEF_RUN_CYCLES  = 25;
    localparam int unsigned DEF_HALT_STABLE = 4;

    // Ceiling log2, usable in parameter and localparam expressions
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rv32i_boot_ctrl_if.sv
// Program-image load stream between the host loader and the boot controller.
// The host is the master; the controller accepts words through the slave modport.
interface rv32i_boot_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            ld_valid;
    logic            ld_ready;
    logic [XLEN-1:0] ld_addr;
    logic [XLEN-1:0] ld_data;
    logic            ld_last;

    modport master (
        output ld_valid,
        output ld_addr,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_addr,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/rv32i_halt_detect.sv
// Detects a core stuck in a self-loop: core_pc unchanged for HALT_STABLE samples.
// The first sample after clear only primes the previous-PC register.
module rv32i_halt_detect
    import rv32i_boot_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned HALT_STABLE = DEF_HALT_STABLE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_halt
);
    localparam int unsigned CW = (clog2(HALT_STABLE + 1) < 1) ? 1 : clog2(HALT_STABLE + 1);
    localparam logic [CW-1:0] LAST = CW'(HALT_STABLE - 1);

    logic [XLEN-1:0] r_prev;
    logic            r_have_prev;
    logic [CW-1:0]   r_cnt;
    logic            w_same;

    assign w_same = r_have_prev && (i_pc == r_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_cnt       <= '0;
        end else if (i_clear) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_cnt       <= '0;
        end else if (i_en) begin
            r_prev      <= i_pc;
            r_have_prev <= 1'b1;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // r_cnt holds the equal samples already seen, so this fires on the HALT_STABLE-th one
    assign o_halt = i_en && w_same && (r_cnt == LAST);

endmodule

// File: rtl/rv32i_boot_ctrl.sv
// Boot and run controller: clears/initialises the RF, streams the program into IMEM,
// releases the core and reports completion by self-loop halt or by cycle budget.
module rv32i_boot_ctrl
    import rv32i_boot_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned IMEM_DEPTH  = 64,
    parameter int unsigned NREG        = 32,
    parameter int unsigned RUN_CYCLES  = DEF_RUN_CYCLES,
    parameter int unsigned HALT_STABLE = DEF_HALT_STABLE,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned IAW        = clog2(IMEM_DEPTH),
    localparam int unsigned RAW        = clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_reg_init_mode,
    rv32i_boot_ctrl_if.slave       ld,
    output logic                   o_imem_we,
    output logic [IAW-1:0]         o_imem_waddr,
    output logic [XLEN-1:0]        o_imem_wdata,
    output logic                   o_rf_we,
    output logic [RAW-1:0]         o_rf_waddr,
    output logic [XLEN-1:0]        o_rf_wdata,
    output logic                   o_core_rst_n,
    input  logic [XLEN-1:0]        i_core_pc,
    output logic [CNT_W-1:0]       o_cycles,
    output logic                   o_done,
    output logic                   o_halted,
    output logic                   o_timeout,
    output logic                   o_addr_err
);
    boot_state_e      r_state, w_state_nxt;

    logic             r_mode;
    logic             r_imem_we;
    logic [IAW-1:0]   r_imem_waddr;
    logic [XLEN-1:0]  r_imem_wdata;
    logic             r_rf_we;
    logic [RAW-1:0]   r_rf_waddr;
    logic [XLEN-1:0]  r_rf_wdata;
    logic [CNT_W-1:0] r_cycles;
    logic             r_halted;
    logic             r_timeout;
    logic             r_addr_err;

    logic             w_hs;
    logic             w_addr_ok;
    logic             w_rf_last;
    logic [RAW-1:0]   w_rf_idx_nxt;
    logic [CNT_W-1:0] w_cycles_nxt;
    logic             w_timeout_hit;
    logic             w_halt;
    logic             w_run;
    logic             w_not_run;
    logic             w_ld_ready;
    logic             w_core_rst_n;
    logic             w_done;

    assign w_run         = (r_state == RUN);
    assign w_not_run     = !w_run;
    assign w_hs          = (r_state == LOAD) && ld.ld_valid;
    assign w_addr_ok     = ld.ld_addr < XLEN'(IMEM_DEPTH);
    assign w_rf_last     = (r_rf_waddr == RAW'(NREG - 1));
    assign w_rf_idx_nxt  = r_rf_waddr + 1'b1;
    assign w_cycles_nxt  = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;
    assign w_timeout_hit = (w_cycles_nxt >= CNT_W'(RUN_CYCLES));

    rv32i_halt_detect #(
        .XLEN        (XLEN),
        .HALT_STABLE (HALT_STABLE)
    ) u_halt_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_not_run),
        .i_en    (w_run),
        .i_pc    (i_core_pc),
        .o_halt  (w_halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ld_ready   = 1'b0;
        w_core_rst_n = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) w_state_nxt = RF_INIT;
            end
            RF_INIT: begin
                if (w_rf_last) w_state_nxt = LOAD;
            end
            LOAD: begin
                w_ld_ready = 1'b1;
                if (w_hs && ld.ld_last) w_state_nxt = RUN;
            end
            RUN: begin
                w_core_rst_n = 1'b1;
                if (w_halt || w_timeout_hit) w_state_nxt = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                if (i_start) w_state_nxt = RF_INIT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_cycles     <= '0;
            r_halted     <= 1'b0;
            r_timeout    <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    // Index 0 writes zero in either mode, so the first RF write is set up here
                    if (i_start) begin
                        r_mode     <= i_reg_init_mode;
                        r_rf_we    <= 1'b1;
                        r_rf_waddr <= '0;
                        r_rf_wdata <= '0;
                        r_cycles   <= '0;
                        r_halted   <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_addr_err <= 1'b0;
                    end
                end
                RF_INIT: begin
                    if (w_rf_last) begin
                        r_rf_we <= 1'b0;
                    end else begin
                        r_rf_waddr <= w_rf_idx_nxt;
                        r_rf_wdata <= r_mode ? XLEN'(w_rf_idx_nxt) : '0;
                    end
                end
                LOAD: begin
                    if (w_hs) begin
                        if (w_addr_ok) begin
                            r_imem_we    <= 1'b1;
                            r_imem_waddr <= ld.ld_addr[IAW-1:0];
                            r_imem_wdata <= ld.ld_data;
                        end else begin
                            r_addr_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_cycles <= w_cycles_nxt;
                    if (w_halt) begin
                        r_halted <= 1'b1;
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ld.ld_ready   = w_ld_ready;
    assign o_core_rst_n  = w_core_rst_n;
    assign o_done        = w_done;
    assign o_imem_we     = r_imem_we;
    assign o_imem_waddr  = r_imem_waddr;
    assign o_imem_wdata  = r_imem_wdata;
    assign o_rf_we       = r_rf_we;
    assign o_rf_waddr    = r_rf_waddr;
    assign o_rf_wdata    = r_rf_wdata;
    assign o_cycles      = r_cycles;
    assign o_halted      = r_halted;
    assign o_timeout     = r_timeout;
    assign o_addr_err    = r_addr_err;

endmodule

// File: tb/tb_rv32i_boot_ctrl.sv
// Self-checking bench for rv32i_boot_ctrl: directed boots checked every cycle
// against expectations derived from the boot sequence rules.
module tb_rv32i_boot_ctrl;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned RUNC  = 25;
    localparam int unsigned HS    = 4;
    localparam int unsigned CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [XLEN-1:0]   core_pc = 32'h100;
    logic              imem_we;
    logic [4:0]        imem_waddr;
    logic [XLEN-1:0]   imem_wdata;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              core_rst_n;
    logic [CNT_W-1:0]  cycles;
    logic              done;
    logic              halted;
    logic              timeout;
    logic              addr_err;

    rv32i_boot_ctrl_if #(.XLEN(XLEN)) ld_if ();

    rv32i_boot_ctrl #(
        .XLEN        (XLEN),
        .IMEM_DEPTH  (DEPTH),
        .NREG        (NREG),
        .RUN_CYCLES  (RUNC),
        .HALT_STABLE (HS),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start),
        .i_reg_init_mode (mode),
        .ld              (ld_if),
        .o_imem_we       (imem_we),
        .o_imem_waddr    (imem_waddr),
        .o_imem_wdata    (imem_wdata),
        .o_rf_we         (rf_we),
        .o_rf_waddr      (rf_waddr),
        .o_rf_wdata      (rf_wdata),
        .o_core_rst_n    (core_rst_n),
        .i_core_pc       (core_pc),
        .o_cycles        (cycles),
        .o_done          (done),
        .o_halted        (halted),
        .o_timeout       (timeout),
        .o_addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    bit   chk_en = 1'b0;
    logic exp_rf_we = 1'b0, exp_mode = 1'b0, exp_ready = 1'b0, exp_run = 1'b0;
    logic exp_done = 1'b0, exp_halted = 1'b0, exp_timeout = 1'b0, exp_err = 1'b0;
    int   exp_cycles = 0;
    int   rf_cnt = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          due;
    } wr_t;
    wr_t wq[$];

    logic [31:0] pcs [RUNC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ld_ready"},   64'(ld_if.ld_ready), 0);
        chk({tag, "_imem_we"},    64'(imem_we), 0);
        chk({tag, "_imem_waddr"}, 64'(imem_waddr), 0);
        chk({tag, "_imem_wdata"}, 64'(imem_wdata), 0);
        chk({tag, "_rf_we"},      64'(rf_we), 0);
        chk({tag, "_rf_waddr"},   64'(rf_waddr), 0);
        chk({tag, "_rf_wdata"},   64'(rf_wdata), 0);
        chk({tag, "_core_rst_n"}, 64'(core_rst_n), 0);
        chk({tag, "_cycles"},     64'(cycles), 0);
        chk({tag, "_done"},       64'(done), 0);
        chk({tag, "_halted"},     64'(halted), 0);
        chk({tag, "_timeout"},    64'(timeout), 0);
        chk({tag, "_addr_err"},   64'(addr_err), 0);
    endtask

    // Per-cycle comparison against the expected boot-sequence view
    always @(negedge clk) begin
        wr_t e;
        if (chk_en && rst_n) begin
            chk("ld_ready",   64'(ld_if.ld_ready), 64'(exp_ready));
            chk("core_rst_n", 64'(core_rst_n), 64'(exp_run));
            chk("done",       64'(done), 64'(exp_done));
            chk("halted",     64'(halted), 64'(exp_halted));
            chk("timeout",    64'(timeout), 64'(exp_timeout));
            chk("addr_err",   64'(addr_err), 64'(exp_err));
            chk("cycles",     64'(cycles), 64'(exp_cycles));
            chk("rf_we",      64'(rf_we), 64'(exp_rf_we));
            if (exp_rf_we) begin
                chk("rf_waddr", 64'(rf_waddr), 64'(rf_cnt));
                chk("rf_wdata", 64'(rf_wdata), exp_mode ? 64'(rf_cnt) : 64'd0);
                rf_cnt++;
            end
            if (wq.size() > 0 && wq[0].due == cyc) begin
                e = wq.pop_front();
                chk("imem_we",    64'(imem_we), 1);
                chk("imem_waddr", 64'(imem_waddr), 64'(e.a[4:0]));
                chk("imem_wdata", 64'(imem_wdata), 64'(e.d));
            end else begin
                chk("imem_we_idle", 64'(imem_we), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = ~m;
        exp_mode = m; rf_cnt = 0; exp_rf_we = 1'b1;
        exp_done = 1'b0; exp_halted = 1'b0; exp_timeout = 1'b0; exp_err = 1'b0; exp_cycles = 0;
        repeat (NREG) tick();
        exp_rf_we = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic last);
        int w;
        w = 0;
        ld_if.ld_valid = 1'b1;
        ld_if.ld_addr  = a;
        ld_if.ld_data  = d;
        ld_if.ld_last  = last;
        while (!ld_if.ld_ready && w < 50) begin
            tick();
            w++;
        end
        if (w == 50) begin
            chk("ld_ready_wait", 0, 1);
            ld_if.ld_valid = 1'b0;
            return;
        end
        tick();
        if (a < DEPTH) wq.push_back('{a: a, d: d, due: cyc});
        else exp_err = 1'b1;
        if (last) begin
            exp_ready  = 1'b0;
            exp_run    = 1'b1;
            exp_cycles = 0;
        end
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
    endtask

    // Outcome of a run from the PC trace alone: halt after HS equal consecutive samples
    // (first sample never compared), else timeout after RUNC cycles; halt wins a tie.
    task automatic model_run(output int n, output bit h);
        int eq;
        eq = 0; n = RUNC; h = 1'b0;
        for (int k = 0; k < RUNC; k++) begin
            if (k > 0 && pcs[k] == pcs[k-1]) eq++;
            else eq = 0;
            if (eq == HS) begin
                n = k + 1;
                h = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_core(input int n, input bit h, input bit poke_start);
        for (int k = 0; k < n; k++) begin
            core_pc = pcs[k];
            start   = poke_start && (k == 1);
            tick();
            exp_cycles = k + 1;
        end
        start = 1'b0;
        exp_run = 1'b0; exp_done = 1'b1; exp_halted = h; exp_timeout = !h;
        core_pc = 32'h100;
    endtask

    initial begin
        int n;
        bit h;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_addr  = '0;
        ld_if.ld_data  = '0;
        ld_if.ld_last  = 1'b0;

        #3;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (3) tick();

        // Boot 1: RF[k]=k, three words, PC always moving -> timeout
        do_start(1'b1);
        send(32'd0, 32'h00222000, 1'b0);
        send(32'd1, 32'h04432800, 1'b0);
        send(32'd2, 32'h10E60001, 1'b1);
        for (int k = 0; k < RUNC; k++) pcs[k] = 32'(4 * k);
        model_run(n, h);
        chk("model_inc_n", 64'(n), 25);
        chk("model_inc_h", 64'(h), 0);
        run_core(n, h, 1'b0);
        repeat (3) tick();

        // Boot 2: RF zeroed, out-of-range addresses, PC parks at 0x14 -> halt; start in RUN ignored
        do_start(1'b0);
        send(32'd47, 32'h01AE6000, 1'b0);
        send(32'd3,  32'h00500093, 1'b0);
        send(32'd31, 32'hCAFEF00D, 1'b0);
        send(32'd32, 32'h12345678, 1'b0);
        send(32'd4,  32'h0000006F, 1'b1);
        for (int k = 0; k < RUNC; k++) pcs[k] = (k < 3) ? 32'(4 * k) : 32'h14;
        model_run(n, h);
        chk("model_hold_n", 64'(n), 8);
        chk("model_hold_h", 64'(h), 1);
        run_core(n, h, 1'b1);
        repeat (3) tick();

        // Boot 3: loader stalls, then halt and budget exhaustion coincide
        do_start(1'b1);
        repeat (3) tick();
        send(32'd5, 32'h00000013, 1'b1);
        for (int k = 0; k < RUNC; k++) pcs[k] = (k < 20) ? 32'(32'h200 + 4 * k) : 32'h400;
        model_run(n, h);
        chk("model_tie_n", 64'(n), 25);
        chk("model_tie_h", 64'(h), 1);
        run_core(n, h, 1'b0);
        repeat (2) tick();

        // Boot 4: reset pulled in the middle of LOAD with a word pending
        do_start(1'b0);
        send(32'd6, 32'hDEADBEEF, 1'b0);
        ld_if.ld_valid = 1'b1;
        ld_if.ld_addr  = 32'd7;
        ld_if.ld_data  = 32'h0BADC0DE;
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_zero("midload");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        wq.delete();
        exp_ready = 1'b0; exp_run = 1'b0; exp_done = 1'b0; exp_halted = 1'b0;
        exp_timeout = 1'b0; exp_err = 1'b0; exp_cycles = 0; exp_rf_we = 1'b0;
        chk_en = 1'b1;
        repeat (5) tick();
        ld_if.ld_valid = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
